// File: rtl/y86_alu_pkg.sv
// Shared definitions for the sequential Y86 execute ALU: op codes, FSM states and CC layout.
package y86_alu_pkg;

    localparam logic [2:0] ALU_ADD = 3'd0;
    localparam logic [2:0] ALU_SUB = 3'd1;
    localparam logic [2:0] ALU_AND = 3'd2;
    localparam logic [2:0] ALU_XOR = 3'd3;
    localparam logic [2:0] ALU_MUL = 3'd4;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StMul  = 2'd1,
        StDone = 2'd2
    } alu_state_e;

    localparam int unsigned CC_ZF = 0;
    localparam int unsigned CC_SF = 1;
    localparam int unsigned CC_OF = 2;
    localparam int unsigned CC_CF = 3;
    localparam int unsigned CC_W  = 4;

    function automatic logic [CC_W-1:0] pack_cc(input logic zf, input logic sf,
                                                input logic of, input logic cf);
        logic [CC_W-1:0] cc;
        cc        = '0;
        cc[CC_ZF] = zf;
        cc[CC_SF] = sf;
        cc[CC_OF] = of;
        cc[CC_CF] = cf;
        return cc;
    endfunction

endpackage

// File: rtl/alu_cc_seq_if.sv
// Operation request / result handshake bundle between the pipeline and the sequential ALU.
interface alu_cc_seq_if #(
    parameter int unsigned WIDTH = 64
) ();

    logic             in_valid;
    logic             in_ready;
    logic [2:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             set_cc;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;
    logic             zf;
    logic             sf;
    logic             of;
    logic             cf;
    logic             busy;

    modport master (
        output in_valid, op, a, b, set_cc, out_ready,
        input  in_ready, out_valid, result, zf, sf, of, cf, busy
    );

    modport slave (
        input  in_valid, op, a, b, set_cc, out_ready,
        output in_ready, out_valid, result, zf, sf, of, cf, busy
    );

endinterface

// File: rtl/alu_mul_iter.sv
// Iterative unsigned shift-add multiplier: one partial product per cycle, WIDTH cycles per product.
module alu_mul_iter #(
    parameter int unsigned WIDTH = 64,
    parameter int unsigned CNT_W = 7
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 done,
    output logic [2*WIDTH-1:0]   product
);

    logic               run_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [WIDTH-1:0]   mcand_q;
    logic [2*WIDTH-1:0] acc_q;
    logic [WIDTH:0]     partial;
    logic [2*WIDTH-1:0] acc_step;

    // Upper half accumulates, lower half holds the not-yet-consumed multiplier bits.
    always_comb begin
        partial  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, mcand_q} : '0);
        acc_step = {partial, acc_q[WIDTH-1:1]};
    end

    assign done    = run_q && (cnt_q == CNT_W'(WIDTH - 1));
    assign product = acc_step;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            run_q   <= 1'b0;
            cnt_q   <= '0;
            mcand_q <= '0;
            acc_q   <= '0;
        end else if (start) begin
            run_q   <= 1'b1;
            cnt_q   <= '0;
            mcand_q <= a;
            acc_q   <= {{WIDTH{1'b0}}, b};
        end else if (run_q) begin
            acc_q <= acc_step;
            cnt_q <= cnt_q + CNT_W'(1);
            if (done) begin
                run_q <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/alu_cc_seq.sv
// Handshaked execute ALU with registered result, conditionally updated CC register and iterative MUL.
module alu_cc_seq
    import y86_alu_pkg::*;
#(
    parameter int unsigned WIDTH = 64,
    parameter int unsigned CNT_W = 7
) (
    input logic         clk,
    input logic         rst,
    alu_cc_seq_if.slave bus
);

    localparam int unsigned MSB = WIDTH - 1;

    alu_state_e         state_q, state_d;
    logic [WIDTH-1:0]   result_q, result_d;
    logic [CC_W-1:0]    cc_q, cc_d;
    logic               set_cc_q, set_cc_d;
    logic               in_ready;
    logic               accept;
    logic               mul_start;
    logic               mul_done;
    logic [2*WIDTH-1:0] mul_product;
    logic [WIDTH:0]     sum;
    logic [WIDTH:0]     diff;
    logic [WIDTH-1:0]   alu_res;
    logic               alu_cf;
    logic               alu_of;

    assign in_ready  = (state_q == StIdle) || ((state_q == StDone) && bus.out_ready);
    assign accept    = bus.in_valid && in_ready;
    assign mul_start = accept && (bus.op == ALU_MUL);

    // Single-cycle datapath; the extra top bit of sum/diff is carry-out / borrow.
    always_comb begin
        sum     = {1'b0, bus.a} + {1'b0, bus.b};
        diff    = {1'b0, bus.a} - {1'b0, bus.b};
        alu_res = '0;
        alu_cf  = 1'b0;
        alu_of  = 1'b0;
        case (bus.op)
            ALU_ADD: begin
                alu_res = sum[MSB:0];
                alu_cf  = sum[WIDTH];
                alu_of  = (bus.a[MSB] == bus.b[MSB]) && (sum[MSB] != bus.a[MSB]);
            end
            ALU_SUB: begin
                alu_res = diff[MSB:0];
                alu_cf  = diff[WIDTH];
                alu_of  = (bus.a[MSB] != bus.b[MSB]) && (diff[MSB] != bus.a[MSB]);
            end
            ALU_AND: alu_res = bus.a & bus.b;
            ALU_XOR: alu_res = bus.a ^ bus.b;
            default: alu_res = '0;
        endcase
    end

    alu_mul_iter #(
        .WIDTH (WIDTH),
        .CNT_W (CNT_W)
    ) u_mul (
        .clk     (clk),
        .rst     (rst),
        .start   (mul_start),
        .a       (bus.a),
        .b       (bus.b),
        .done    (mul_done),
        .product (mul_product)
    );

    always_comb begin
        state_d  = state_q;
        result_d = result_q;
        cc_d     = cc_q;
        set_cc_d = set_cc_q;
        case (state_q)
            StIdle, StDone: begin
                if ((state_q == StDone) && bus.out_ready) begin
                    state_d = StIdle;
                end
                if (accept) begin
                    if (bus.op == ALU_MUL) begin
                        state_d  = StMul;
                        set_cc_d = bus.set_cc;
                    end else begin
                        state_d  = StDone;
                        result_d = alu_res;
                        if (bus.set_cc) begin
                            cc_d = pack_cc(alu_res == '0, alu_res[MSB], alu_of, alu_cf);
                        end
                    end
                end
            end
            StMul: begin
                if (mul_done) begin
                    state_d  = StDone;
                    result_d = mul_product[MSB:0];
                    if (set_cc_q) begin
                        cc_d = pack_cc(mul_product[MSB:0] == '0, mul_product[MSB], 1'b0,
                                       |mul_product[2*WIDTH-1:WIDTH]);
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= StIdle;
            result_q <= '0;
            cc_q     <= '0;
            set_cc_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            result_q <= result_d;
            cc_q     <= cc_d;
            set_cc_q <= set_cc_d;
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = (state_q == StDone);
    assign bus.busy      = (state_q == StMul);
    assign bus.result    = result_q;
    assign bus.zf        = cc_q[CC_ZF];
    assign bus.sf        = cc_q[CC_SF];
    assign bus.of        = cc_q[CC_OF];
    assign bus.cf        = cc_q[CC_CF];

endmodule

// File: tb/tb_alu_cc_seq.sv
// Bench for alu_cc_seq: directed cases with literal expectations plus randomized traffic on an
// 8-bit instance checked every cycle against a transaction-level model; 64-bit instance for wide cases.
module tb_alu_cc_seq;

    localparam int unsigned W = 8;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   n_cmp = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    alu_cc_seq_if #(.WIDTH(W))  bus8  ();
    alu_cc_seq_if #(.WIDTH(64)) bus64 ();

    alu_cc_seq #(.WIDTH(W), .CNT_W(4)) dut8 (
        .clk (clk),
        .rst (rst),
        .bus (bus8.slave)
    );

    alu_cc_seq #(.WIDTH(64), .CNT_W(7)) dut64 (
        .clk (clk),
        .rst (rst),
        .bus (bus64.slave)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference: result and {zf,sf,of,cf} from plain integer arithmetic on W-bit operands.
    function automatic void ref_op(input logic [2:0] o, input logic [W-1:0] x,
                                   input logic [W-1:0] y, output logic [W-1:0] r,
                                   output logic [3:0] f);
        longint unsigned ux, uy, full;
        longint          sx, sy, sr, hi, lo;
        logic            c, v;
        ux = x; uy = y;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        hi = (64'sd1 <<< (W - 1)) - 1;
        lo = -(64'sd1 <<< (W - 1));
        c = 1'b0; v = 1'b0; sr = 0;
        case (o)
            3'd0: begin full = ux + uy; c = (full >> W) != 0; sr = sx + sy; v = (sr > hi) || (sr < lo); end
            3'd1: begin full = ux - uy; c = ux < uy;          sr = sx - sy; v = (sr > hi) || (sr < lo); end
            3'd2: full = ux & uy;
            3'd3: full = ux ^ uy;
            3'd4: begin full = ux * uy; c = (full >> W) != 0; end
            default: full = 0;
        endcase
        r = full[W-1:0];
        f = {r == '0, r[W-1], v, c};
    endfunction

    // Model: at most one op held; m_wait counts cycles until its result appears.
    logic         m_have;
    int           m_wait;
    logic [W-1:0] m_res, m_pres;
    logic [3:0]   m_cc, m_ncc;
    logic         m_ov, m_bz, m_ir, m_acc;
    logic [W-1:0] r_tmp;
    logic [3:0]   f_tmp;

    initial begin
        m_have = 1'b0; m_wait = 0; m_res = '0; m_pres = '0; m_cc = '0; m_ncc = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                m_have = 1'b0; m_wait = 0; m_res = '0; m_cc = '0;
            end else begin
                m_ov = m_have && (m_wait == 0);
                m_bz = m_have && (m_wait > 0);
                m_ir = !m_have || (m_ov && bus8.out_ready);
                chk("in_ready", bus8.in_ready, m_ir);
                chk("out_valid", bus8.out_valid, m_ov);
                chk("busy", bus8.busy, m_bz);
                chk("flags", {bus8.zf, bus8.sf, bus8.of, bus8.cf}, m_cc);
                if (m_ov) chk("result", bus8.result, m_res);
                m_acc = bus8.in_valid && m_ir;
                if (m_bz) begin
                    m_wait--;
                    if (m_wait == 0) begin
                        m_res = m_pres;
                        m_cc  = m_ncc;
                    end
                end else if (m_ov && bus8.out_ready) begin
                    m_have = 1'b0;
                end
                if (m_acc) begin
                    ref_op(bus8.op, bus8.a, bus8.b, r_tmp, f_tmp);
                    m_have = 1'b1;
                    m_pres = r_tmp;
                    m_ncc  = bus8.set_cc ? f_tmp : m_cc;
                    if (bus8.op == 3'd4) begin
                        m_wait = W;
                    end else begin
                        m_wait = 0;
                        m_res  = r_tmp;
                        m_cc   = m_ncc;
                    end
                end
            end
        end
    end

    task automatic send(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                        input logic sc);
        bus8.in_valid = 1'b1; bus8.op = o; bus8.a = x; bus8.b = y; bus8.set_cc = sc;
        for (int t = 0; t < 100; t++) begin
            @(negedge clk);
            if (bus8.in_ready) begin
                tick();
                bus8.in_valid = 1'b0;
                return;
            end
            tick();
        end
        n_cmp++; n_err++;
        $display("FAIL send_timeout: in_ready stayed 0, expected 1 within 100 cycles");
        bus8.in_valid = 1'b0;
    endtask

    function automatic logic [W-1:0] pick();
        case ($urandom_range(0, 5))
            0:       return '0;
            1:       return 8'hFF;
            2:       return 8'h7F;
            3:       return 8'h80;
            default: return W'($urandom);
        endcase
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    int lat;

    initial begin
        bus8.in_valid = 1'b0; bus8.op = '0; bus8.a = '0; bus8.b = '0; bus8.set_cc = 1'b0;
        bus8.out_ready = 1'b1;
        bus64.in_valid = 1'b0; bus64.op = '0; bus64.a = '0; bus64.b = '0; bus64.set_cc = 1'b0;
        bus64.out_ready = 1'b1;

        // Reset values
        #1 rst = 1'b1;
        #2;
        chk("rst_in_ready", bus8.in_ready, 1);
        chk("rst_out_valid", bus8.out_valid, 0);
        chk("rst_busy", bus8.busy, 0);
        chk("rst_result", bus8.result, 0);
        chk("rst_flags", {bus8.zf, bus8.sf, bus8.of, bus8.cf}, 0);
        chk("rst64_result", bus64.result, 0);
        @(negedge clk);
        #2 rst = 1'b0;
        tick();

        // 64-bit ADD overflow
        bus64.in_valid = 1'b1; bus64.op = 3'd0; bus64.set_cc = 1'b1;
        bus64.a = 64'h7FFF_FFFF_FFFF_FFFF; bus64.b = 64'd1;
        tick();
        bus64.in_valid = 1'b0;
        @(negedge clk);
        chk("add64_valid", bus64.out_valid, 1);
        chk("add64_result", bus64.result, 64'h8000_0000_0000_0000);
        chk("add64_zsoc", {bus64.zf, bus64.sf, bus64.of, bus64.cf}, 4'b0110);
        tick();

        // 64-bit MUL latency and carry from the high half
        bus64.in_valid = 1'b1; bus64.op = 3'd4; bus64.set_cc = 1'b1;
        bus64.a = 64'hFFFF_FFFF_FFFF_FFFF; bus64.b = 64'd2;
        tick();
        bus64.in_valid = 1'b0;
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!bus64.out_valid && lat < 200);
        chk("mul64_latency", 64'(lat), 65);
        chk("mul64_result", bus64.result, 64'hFFFF_FFFF_FFFF_FFFE);
        chk("mul64_zsoc", {bus64.zf, bus64.sf, bus64.of, bus64.cf}, 4'b0101);
        tick();

        // SUB zero, then SUB borrow
        send(3'd1, 8'd5, 8'd5, 1'b1);
        @(negedge clk);
        chk("sub_eq_result", bus8.result, 0);
        chk("sub_eq_zf_cf", {bus8.zf, bus8.cf}, 2'b10);
        tick();
        send(3'd1, 8'd3, 8'd5, 1'b1);
        @(negedge clk);
        chk("sub_lt_result", bus8.result, 8'hFE);
        chk("sub_lt_zsoc", {bus8.zf, bus8.sf, bus8.of, bus8.cf}, 4'b0101);
        tick();

        // XOR without CC update leaves flags alone
        send(3'd3, 8'hFF, 8'hFF, 1'b0);
        @(negedge clk);
        chk("xor_hold_result", bus8.result, 0);
        chk("xor_hold_zsoc", {bus8.zf, bus8.sf, bus8.of, bus8.cf}, 4'b0101);
        tick();

        // MUL 0x10*0x20: busy for W cycles, an offered ADD is refused meanwhile
        send(3'd4, 8'h10, 8'h20, 1'b1);
        bus8.in_valid = 1'b1; bus8.op = 3'd0; bus8.a = 8'd1; bus8.b = 8'd1;
        for (int k = 1; k <= W; k++) begin
            @(negedge clk);
            chk("mul_busy", bus8.busy, 1);
            chk("mul_in_ready", bus8.in_ready, 0);
            if (k == 6) begin
                tick();
                bus8.in_valid = 1'b0;
            end
        end
        @(negedge clk);
        chk("mul_valid", bus8.out_valid, 1);
        chk("mul_result", bus8.result, 0);
        chk("mul_zf_cf", {bus8.zf, bus8.cf}, 2'b11);
        tick();

        // Back-pressure then back-to-back drain
        bus8.out_ready = 1'b0;
        send(3'd0, 8'h11, 8'h22, 1'b1);
        bus8.in_valid = 1'b1; bus8.op = 3'd0; bus8.a = 8'h40; bus8.b = 8'h50; bus8.set_cc = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("bp_hold_result", bus8.result, 8'h33);
            chk("bp_in_ready", bus8.in_ready, 0);
            tick();
        end
        bus8.out_ready = 1'b1;
        @(negedge clk);
        chk("bp_release_ready", bus8.in_ready, 1);
        tick();
        bus8.a = 8'h01; bus8.b = 8'hFF;
        @(negedge clk);
        chk("b2b_second", bus8.result, 8'h90);
        chk("b2b_second_of", bus8.of, 1);
        tick();
        bus8.in_valid = 1'b0;
        @(negedge clk);
        chk("b2b_third", bus8.result, 8'h00);
        chk("b2b_third_zf_cf", {bus8.zf, bus8.cf}, 2'b11);
        tick();

        // Asynchronous reset in the middle of a MUL
        send(3'd4, 8'h03, 8'h05, 1'b1);
        repeat (3) @(posedge clk);
        #3 rst = 1'b1;
        #1;
        chk("arst_out_valid", bus8.out_valid, 0);
        chk("arst_busy", bus8.busy, 0);
        chk("arst_in_ready", bus8.in_ready, 1);
        chk("arst_result", bus8.result, 0);
        chk("arst_flags", {bus8.zf, bus8.sf, bus8.of, bus8.cf}, 0);
        @(negedge clk);
        #2 rst = 1'b0;
        tick();
        send(3'd0, 8'd2, 8'd3, 1'b1);
        @(negedge clk);
        chk("post_rst_add", bus8.result, 8'd5);
        tick();

        // Randomized traffic; the model process checks every cycle
        repeat (400) begin
            bus8.in_valid  = ($urandom_range(0, 9) < 6);
            bus8.op        = 3'($urandom_range(0, 7));
            bus8.a         = pick();
            bus8.b         = pick();
            bus8.set_cc    = 1'($urandom_range(0, 1));
            bus8.out_ready = ($urandom_range(0, 9) < 7);
            tick();
        end
        bus8.in_valid  = 1'b0;
        bus8.out_ready = 1'b1;
        repeat (20) tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/alu_cc_seq.md
Name: alu_cc_seq

Overview:
- Parametrised, handshaked successor to the combinational execute ALU.
- Adds a registered result, a condition-code register (ZF/SF/OF/CF) with conditional update, and an iterative multi-cycle MUL.
- Sits between decode/register-read and write-back in the pipelined Y86 core.
- Accepts one operation at a time over valid/ready and returns it over valid/ready.

Parameters:
- WIDTH, 64, operand and result width in bits; legal range 8..64.
- CNT_W, 7, width of the MUL iteration counter; must satisfy 2^CNT_W > WIDTH.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  an operation is presented.
- in_ready  out  1  the block can accept an operation this cycle.
- op  in  3  operation code: 0 ADD, 1 SUB, 2 AND, 3 XOR, 4 MUL, 5..7 reserved.
- a  in  WIDTH  operand A, two's complement.
- b  in  WIDTH  operand B, two's complement.
- set_cc  in  1  update the CC register when this operation completes.
- out_valid  out  1  result is valid.
- out_ready  in  1  the consumer takes the result.
- result  out  WIDTH  registered result.
- zf, sf, of, cf  out  1 each  CC register contents.
- busy  out  1  a MUL is iterating.

Behaviour:
- Reset (asynchronous, takes effect immediately):
  - state goes to IDLE.
  - result, out_valid, busy, zf, sf, of and cf all go to 0.
  - in_ready goes to 1.
  - Reset during a MUL aborts it with no CC update.
- Handshake:
  - A transfer occurs when in_valid and in_ready are both high on a rising edge; operands, op and set_cc are latched.
  - The output transfer occurs when out_valid and out_ready are both high.
  - result and the flags are held stable while out_valid is high and out_ready is low.
  - in_ready = (state==IDLE) or (state==DONE and out_ready). This allows back-to-back single-cycle operations at one per cycle.
- States:
  - IDLE: on accept of op 0..3 or 5..7, go to DONE. On accept of op 4, go to MUL.
  - MUL: iterate for WIDTH cycles, then go to DONE.
  - DONE: out_valid=1. If out_ready, go to IDLE, or re-accept per the in_ready rule.
- Latency:
  - Ops 0..3 and 5..7: out_valid is high one cycle after accept.
  - MUL: out_valid is high WIDTH+1 cycles after accept.
  - busy=1 exactly while in MUL.
- Arithmetic (WIDTH-bit, wraps modulo 2^WIDTH):
  - ADD: r = a+b. CF = unsigned carry-out. OF = (a[msb]==b[msb]) and (r[msb]!=a[msb]).
  - SUB: r = a-b. CF = 1 iff a<b unsigned (borrow). OF = (a[msb]!=b[msb]) and (r[msb]!=a[msb]).
  - AND, XOR: bitwise. CF=0, OF=0.
  - MUL: unsigned shift-add, one partial product per cycle, full 2*WIDTH-bit accumulator. r = low WIDTH bits. CF = 1 iff the high WIDTH bits are nonzero. OF=0.
  - Reserved ops: r=0, CF=0, OF=0.
  - All ops: ZF = (r==0), SF = r[msb].
- CC register:
  - Written on the edge that enters DONE, only if the latched set_cc=1; otherwise it holds its value.
  - zf/sf/of/cf always reflect the register, never the in-flight operation.
- Boundaries:
  - in_valid while busy: ignored, no transfer, because in_ready=0.
  - Operands changing after accept have no effect.
  - MUL with a=0 or b=0 still takes the full WIDTH cycles.

Decomposition:
- Shared package y86_alu_pkg:
  - Op-code constants ALU_ADD..ALU_MUL.
  - State encoding IDLE/MUL/DONE.
  - CC bit-index constants.
- One sub-module, alu_mul_iter: the shift-add multiplier with start, done, counter and accumulator.
- Add/sub/logic and the flag computation stay inline.

Test Plan:
- ADD overflow (WIDTH=64): a=0x7FFF_FFFF_FFFF_FFFF, b=1, set_cc=1 -> next cycle result=0x8000_0000_0000_0000, of=1, sf=1, zf=0, cf=0.
- SUB zero/borrow (WIDTH=8): a=5, b=5 gives zf=1, cf=0. Then a=3, b=5 gives result=0xFE, cf=1, sf=1, of=0.
- set_cc=0 hold: after the SUB above, XOR a=0xFF, b=0xFF with set_cc=0 -> result=0, flags still zf=0, sf=1, cf=1.
- MUL (WIDTH=8): a=0x10, b=0x20 -> busy for 8 cycles, out_valid at cycle 9, result=0x00, cf=1, zf=1. in_valid during busy gives in_ready=0 and the op is not accepted.
- Back-pressure/back-to-back: three ADDs with out_ready low for 3 cycles -> result held stable. Then out_ready high -> one result per cycle, in order.
- Async reset mid-MUL: assert rst on MUL cycle 4 -> outputs 0 immediately, in_ready=1, CC=0, and the next ADD completes normally.
